clock_setter: RTL and testbench

CLOCK_SETTER -- requirements
Module: clock_setter

---
 rtl/clock_pkg.sv | 7 +
 rtl/btn_edge.sv | 19 +
 rtl/clock_setter.sv | 92 +++++++++
 tb/tb_clock_setter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: field limits and the FSM state encoding shared by the clock-setting logic.
package clock_pkg;
  localparam logic [3:0] HOURS_MAX   = 4'd12;
  localparam logic [5:0] MINUTES_MAX = 6'd60;
  localparam logic [5:0] SECONDS_MAX = 6'd60;
  typedef enum logic [2:0] {IDLE, SET_H, SET_M, SET_S, COMMIT} state_t;
endpackage

// File: rtl/btn_edge.sv
// btn_edge: registered rising-edge detector; a button held through reset stays silent until released.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);
  logic btn_q, arm_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q <= 1'b0;
      arm_q <= ~btn_i;
    end else begin
      btn_q <= btn_i;
      arm_q <= arm_q | ~btn_i;
    end
  end
  assign rise_o = btn_i & ~btn_q & arm_q;
endmodule

// File: rtl/clock_setter.sv
// clock_setter: button-driven hours/minutes/seconds editor with a one-cycle commit strobe.
// Define CLOCK_SETTER_AUTOREPEAT_EN to enable auto-repeat while inc_btn is held.
module clock_setter import clock_pkg::*; #(
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic [3:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  output logic       adjust_clock,
  output logic [3:0] in_hours,
  output logic [5:0] in_minutes,
  output logic [5:0] in_seconds,
  output logic [1:0] edit_field
);
  state_t state_q;
  logic [3:0] h_q;
  logic [5:0] m_q, s_q;
  logic [1:0] fld_q;
  logic adj_q, mode_e, inc_e, rpt, bump;
  btn_edge u_mode (.clk(clk), .rst(rst), .btn_i(mode_btn), .rise_o(mode_e));
  btn_edge u_inc (.clk(clk), .rst(rst), .btn_i(inc_btn), .rise_o(inc_e));
`ifdef CLOCK_SETTER_AUTOREPEAT_EN
  localparam int CW = $clog2(REPEAT_DELAY + 1);
  logic act_q, hold;
  logic [CW-1:0] cnt_q;
  assign hold = inc_btn & ~mode_e & (state_q inside {SET_H, SET_M, SET_S});
  assign rpt = act_q & hold & (cnt_q == CW'(REPEAT_DELAY - 1));
  // After the first repeat the counter reloads so later repeats come every REPEAT_RATE cycles
  always_ff @(posedge clk) begin
    if (rst || !hold) begin
      act_q <= 1'b0;
      cnt_q <= '0;
    end else if (inc_e) begin
      act_q <= 1'b1;
      cnt_q <= '0;
    end else if (act_q) begin
      cnt_q <= rpt ? CW'(REPEAT_DELAY - REPEAT_RATE) : cnt_q + 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
  assign rpt = 1'b0;
`endif
  assign bump = inc_e | rpt;
  // mode_btn wins over inc_btn because the increment sits in the else branch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      h_q     <= '0;
      m_q     <= '0;
      s_q     <= '0;
      fld_q   <= 2'd0;
      adj_q   <= 1'b0;
    end else begin
      adj_q <= 1'b0;
      case (state_q)
        IDLE: if (mode_e) begin
          state_q <= SET_H;
          fld_q   <= 2'd1;
          h_q     <= hours >= HOURS_MAX ? 4'd0 : hours;
          m_q     <= minutes >= MINUTES_MAX ? 6'd0 : minutes;
          s_q     <= seconds >= SECONDS_MAX ? 6'd0 : seconds;
        end
        SET_H: if (mode_e) begin
          state_q <= SET_M;
          fld_q   <= 2'd2;
        end else if (bump) h_q <= h_q == HOURS_MAX - 4'd1 ? 4'd0 : h_q + 4'd1;
        SET_M: if (mode_e) begin
          state_q <= SET_S;
          fld_q   <= 2'd3;
        end else if (bump) m_q <= m_q == MINUTES_MAX - 6'd1 ? 6'd0 : m_q + 6'd1;
        SET_S: if (mode_e) begin
          state_q <= COMMIT;
          fld_q   <= 2'd0;
          adj_q   <= 1'b1;
        end else if (bump) s_q <= s_q == SECONDS_MAX - 6'd1 ? 6'd0 : s_q + 6'd1;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign adjust_clock = adj_q;
  assign edit_field   = fld_q;
  assign in_hours     = h_q;
  assign in_minutes   = m_q;
  assign in_seconds   = s_q;
endmodule

// File: tb/tb_clock_setter.sv
// tb_clock_setter: directed scenarios plus randomized button/time traffic against a behavioural model.
module tb_clock_setter;
  localparam int DELAY = 50;
  localparam int RATE = 10;
  logic clk = 1'b0, rst, mode_btn, inc_btn, adjust_clock;
  logic [3:0] hours, in_hours;
  logic [5:0] minutes, seconds, in_minutes, in_seconds;
  logic [1:0] edit_field;
  int checks = 0, errors = 0;
  int m_st, m_h, m_m, m_s, m_adj, held;
  bit pm, pi, arm_m, arm_i;

  clock_setter #(.REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)) dut (
    .clk(clk), .rst(rst), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .hours(hours), .minutes(minutes), .seconds(seconds),
    .adjust_clock(adjust_clock), .in_hours(in_hours), .in_minutes(in_minutes),
    .in_seconds(in_seconds), .edit_field(edit_field)
  );

  always #5 clk = ~clk;

  // Model: mode index 0=idle,1..3=editing h/m/s,4=commit; a press counts only once the button was seen released.
  task automatic model_step();
    bit me, ie, rep;
    if (rst) begin
      m_st = 0; m_h = 0; m_m = 0; m_s = 0; m_adj = 0; held = -1;
      pm = 0; pi = 0; arm_m = !mode_btn; arm_i = !inc_btn;
      return;
    end
    me = mode_btn && !pm && arm_m;
    ie = inc_btn && !pi && arm_i;
    arm_m = arm_m || !mode_btn; arm_i = arm_i || !inc_btn;
    pm = mode_btn; pi = inc_btn;
`ifdef CLOCK_SETTER_AUTOREPEAT_EN
    if (!(m_st >= 1 && m_st <= 3) || !inc_btn || me) held = -1;
    else if (ie) held = 0;
    else if (held >= 0) held++;
    rep = held >= DELAY && (held - DELAY) % RATE == 0;
`else
    rep = 0;
`endif
    m_adj = 0;
    case (m_st)
      0: if (me) begin
        m_st = 1;
        m_h = hours >= 12 ? 0 : int'(hours);
        m_m = minutes >= 60 ? 0 : int'(minutes);
        m_s = seconds >= 60 ? 0 : int'(seconds);
      end
      1: if (me) m_st = 2; else if (ie || rep) m_h = (m_h + 1) % 12;
      2: if (me) m_st = 3; else if (ie || rep) m_m = (m_m + 1) % 60;
      3: if (me) begin m_st = 4; m_adj = 1; end else if (ie || rep) m_s = (m_s + 1) % 60;
      default: m_st = 0;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1; mode_btn = 0; inc_btn = 0;
    tick(); tick();
    rst = 0;
    tick();
  endtask

  task automatic press_mode();
    mode_btn = 1; tick();
    mode_btn = 0; tick();
  endtask

  task automatic test_reset();
    rst = 1; mode_btn = 1; inc_btn = 1;
    hours = 4'($urandom); minutes = 6'($urandom); seconds = 6'($urandom);
    tick(); tick();
    checks++; if (adjust_clock !== 1'b0) begin errors++; $display("FAIL reset_adj got %b want 0", adjust_clock); end
    checks++; if (edit_field !== 2'd0) begin errors++; $display("FAIL reset_field got %0d want 0", edit_field); end
    checks++; if ({in_hours, in_minutes, in_seconds} !== 16'd0) begin errors++; $display("FAIL reset_time got %0d:%0d:%0d want 0:0:0", in_hours, in_minutes, in_seconds); end
    rst = 0;
    repeat (3) tick();
    checks++; if (edit_field !== 2'd0) begin errors++; $display("FAIL held_through_reset got %0d want 0", edit_field); end
    mode_btn = 0; inc_btn = 0; tick();
    mode_btn = 1; tick();
    checks++; if (edit_field !== 2'd1) begin errors++; $display("FAIL press_after_release got %0d want 1", edit_field); end
    mode_btn = 0; tick();
  endtask

  task automatic test_snapshot();
    do_reset();
    hours = 4'd10; minutes = 6'd59; seconds = 6'd30;
    mode_btn = 1; tick();
    checks++; if (edit_field !== 2'd1) begin errors++; $display("FAIL snap_field got %0d want 1", edit_field); end
    checks++; if (in_hours !== 4'd10 || in_minutes !== 6'd59 || in_seconds !== 6'd30) begin errors++; $display("FAIL snap_time got %0d:%0d:%0d want 10:59:30", in_hours, in_minutes, in_seconds); end
    mode_btn = 0; tick();
    hours = 4'd1; minutes = 6'd2; seconds = 6'd3;
  endtask

  task automatic test_hour_wrap();
    inc_btn = 1; tick();
    checks++; if (in_hours !== 4'd11) begin errors++; $display("FAIL hour_inc got %0d want 11", in_hours); end
    inc_btn = 0; tick();
    inc_btn = 1; tick();
    checks++; if (in_hours !== 4'd0) begin errors++; $display("FAIL hour_wrap got %0d want 0", in_hours); end
    checks++; if (in_minutes !== 6'd59) begin errors++; $display("FAIL hour_no_carry got %0d want 59", in_minutes); end
    inc_btn = 0; tick();
  endtask

  task automatic test_minute_wrap_commit();
    int p = 0;
    press_mode();
    checks++; if (edit_field !== 2'd2) begin errors++; $display("FAIL field_min got %0d want 2", edit_field); end
    inc_btn = 1; tick();
    checks++; if (in_minutes !== 6'd0 || in_hours !== 4'd0) begin errors++; $display("FAIL min_wrap got %0d:%0d want 0:0", in_hours, in_minutes); end
    inc_btn = 0; tick();
    press_mode();
    checks++; if (edit_field !== 2'd3 || adjust_clock !== 1'b0) begin errors++; $display("FAIL field_sec got %0d/%b want 3/0", edit_field, adjust_clock); end
    mode_btn = 1; tick();
    if (adjust_clock) p++;
    checks++; if (in_hours !== 4'd0 || in_minutes !== 6'd0 || in_seconds !== 6'd30) begin errors++; $display("FAIL commit_time got %0d:%0d:%0d want 0:0:30", in_hours, in_minutes, in_seconds); end
    mode_btn = 0;
    repeat (10) begin tick(); if (adjust_clock) p++; end
    checks++; if (p != 1) begin errors++; $display("FAIL commit_pulses got %0d want 1", p); end
    checks++; if (edit_field !== 2'd0 || in_seconds !== 6'd30) begin errors++; $display("FAIL idle_hold got %0d/%0d want 0/30", edit_field, in_seconds); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    hours = 4'd3; minutes = 6'd4; seconds = 6'd5;
    repeat (3) press_mode();
    mode_btn = 1; inc_btn = 1; tick();
    checks++; if (edit_field !== 2'd0 || adjust_clock !== 1'b1) begin errors++; $display("FAIL same_cycle_state got %0d/%b want 0/1", edit_field, adjust_clock); end
    checks++; if (in_seconds !== 6'd5) begin errors++; $display("FAIL same_cycle_sec got %0d want 5", in_seconds); end
    mode_btn = 0; inc_btn = 0; tick();
  endtask

  task automatic test_reset_mid_edit();
    int p = 0;
    do_reset();
    hours = 4'd7; minutes = 6'd8; seconds = 6'd9;
    press_mode(); press_mode();
    inc_btn = 1; tick(); inc_btn = 0; tick();
    checks++; if (in_minutes !== 6'd9) begin errors++; $display("FAIL mid_inc got %0d want 9", in_minutes); end
    rst = 1; tick();
    checks++; if (edit_field !== 2'd0 || {in_hours, in_minutes, in_seconds} !== 16'd0 || adjust_clock !== 1'b0) begin errors++; $display("FAIL mid_reset got %0d %0d:%0d:%0d %b want 0 0:0:0 0", edit_field, in_hours, in_minutes, in_seconds, adjust_clock); end
    rst = 0;
    repeat (20) begin tick(); if (adjust_clock) p++; end
    checks++; if (p != 0) begin errors++; $display("FAIL mid_no_pulse got %0d want 0", p); end
  endtask

  task automatic test_autorepeat();
    do_reset();
    hours = 4'd2; minutes = 6'd3; seconds = 6'd0;
    repeat (3) press_mode();
    inc_btn = 1; repeat (80) tick();
    inc_btn = 0; tick();
`ifdef CLOCK_SETTER_AUTOREPEAT_EN
    checks++; if (in_seconds !== 6'd4) begin errors++; $display("FAIL autorepeat got %0d want 4", in_seconds); end
`else
    checks++; if (in_seconds !== 6'd1) begin errors++; $display("FAIL hold_no_repeat got %0d want 1", in_seconds); end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) mode_btn = ~mode_btn;
      if ($urandom_range(0, 3) == 0) inc_btn = ~inc_btn;
      rst = $urandom_range(0, 199) == 0;
      hours = 4'($urandom); minutes = 6'($urandom); seconds = 6'($urandom);
      tick();
      checks++; if (adjust_clock !== 1'(m_adj)) begin errors++; $display("FAIL rnd_adj cyc %0d got %b want %0d", i, adjust_clock, m_adj); end
      checks++; if (edit_field !== 2'((m_st >= 1 && m_st <= 3) ? m_st : 0)) begin errors++; $display("FAIL rnd_field cyc %0d got %0d model_mode %0d", i, edit_field, m_st); end
      checks++; if (in_hours !== 4'(m_h) || in_minutes !== 6'(m_m) || in_seconds !== 6'(m_s)) begin errors++; $display("FAIL rnd_time cyc %0d got %0d:%0d:%0d want %0d:%0d:%0d", i, in_hours, in_minutes, in_seconds, m_h, m_m, m_s); end
      checks++; if (in_hours >= 4'd12 || in_minutes >= 6'd60 || in_seconds >= 6'd60) begin errors++; $display("FAIL rnd_range cyc %0d got %0d:%0d:%0d", i, in_hours, in_minutes, in_seconds); end
    end
  endtask

  initial begin
    rst = 1; mode_btn = 0; inc_btn = 0; hours = 0; minutes = 0; seconds = 0;
    test_reset();
    test_snapshot();
    test_hour_wrap();
    test_minute_wrap_commit();
    test_same_cycle();
    test_reset_mid_edit();
    test_autorepeat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
